// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes the instruction memory
//
// Purpose:
//   Receives a frame from the host as {len_lo, len_hi, data[len], checksum} over a
//   valid/ready handshake. Each data byte is written to instruction memory at
//   ascending addresses from 0. The processor is held until a frame completes
//   with a matching 8-bit additive checksum.
//
// Ports:
//   clk, reset      system clock; asynchronous active-high reset
//   start           1-cycle pulse, begins a frame from IDLE/DONE/ERROR
//   in_data         host stream byte
//   in_valid        host byte valid
//   in_ready        loader can accept a byte (decoded from state)
//   imem_we         instruction-memory write strobe, one cycle after each data byte
//   imem_addr       write address (held when imem_we=0)
//   imem_wdata      write data (held when imem_we=0)
//   busy            frame in progress
//   done            last frame loaded with good checksum
//   error           last frame rejected (oversize or bad checksum)
//   cpu_hold        processor stall, low only in DONE
module program_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam int LEN_W = 2 * DATA_W;
  // One extra bit so a full-memory program (len == 2**ADDR_W) can be counted.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sum_q;

  logic              xfer;
  logic [LEN_W-1:0]  new_len;
  logic              len_too_big;
  logic              last_data;

  assign xfer        = in_valid & in_ready;
  // Full length as it will be once the high byte now on in_data is accepted.
  assign new_len     = {in_data, len_q[DATA_W-1:0]};
  assign len_too_big = {1'b0, new_len} > MAX_LEN;
  assign last_data   = LEN_W'(cnt_q) == (len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // in_valid is used directly below: in these states in_ready is 1, so it
  // equals a transfer without feeding in_ready back into its own block.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (len_too_big)            state_d = ERROR;
          else if (new_len == '0)     state_d = CHECK;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_data) state_d = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = (in_data == sum_q) ? DONE : ERROR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_d = LEN_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        case (state_q)
          LEN_LO: len_q[DATA_W-1:0] <= in_data;
          LEN_HI: begin
            len_q[LEN_W-1:DATA_W] <= in_data;
            cnt_q <= '0;
            sum_q <= '0;
          end
          DATA: begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt_q[ADDR_W-1:0];
            imem_wdata <= in_data;
            sum_q      <= sum_q + in_data;
            cnt_q      <= cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - bench for program_loader
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       imem_we;
  logic [9:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       busy, done, error, cpu_hold;

  program_loader #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [0:7][7:0] b;
    int              gap;
    bit              busy_start;
    bit              exp_done;
    bit              exp_error;
  } vec_t;

  vec_t        vecs [8];
  logic [17:0] sb [$];
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          first_wr = 0;
  int          last_wr = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_count++;
      if (wr_count == 1) first_wr = cyc;
      last_wr = cyc;
      nvec++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          nfail++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   imem_addr, imem_wdata, e[17:8], e[7:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      nvec++;
      nfail++;
      $display("FAIL handshake_timeout: got in_ready 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int len = 0;
    int nexp = 0;
    bit oversize = 0;
    wr_count = 0;
    pulse_start();
    chk($sformatf("v%0d_busy_after_start", idx), busy, 1);
    chk($sformatf("v%0d_hold_after_start", idx), cpu_hold, 1);
    chk($sformatf("v%0d_done_after_start", idx), done, 0);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0 && v.gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        for (int g = 0; g < v.gap; g++) begin
          start = (v.busy_start && i == 3 && g == 0);
          @(negedge clk);
        end
        start = 1'b0;
      end
      if (i == 1) begin
        len = {v.b[1], v.b[0]};
        oversize = (len > 1024);
      end
      if (i >= 2 && !oversize && i < 2 + len) begin
        sb.push_back({10'(i - 2), v.b[i]});
        nexp++;
      end
      send_byte(v.b[i]);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_done", idx), done, v.exp_done);
    chk($sformatf("v%0d_error", idx), error, v.exp_error);
    chk($sformatf("v%0d_cpu_hold", idx), cpu_hold, !v.exp_done);
    chk($sformatf("v%0d_busy", idx), busy, 0);
    chk($sformatf("v%0d_in_ready", idx), in_ready, 0);
    chk($sformatf("v%0d_writes", idx), wr_count, nexp);
    chk($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
    if (v.gap == 0 && nexp > 1)
      chk($sformatf("v%0d_write_span", idx), last_wr - first_wr, nexp - 1);
  endtask

  initial begin
    logic [7:0] b, sum;

    vecs[0] = '{6, {8'h03, 8'h00, 8'h2B, 8'h2B, 8'h2E, 8'h84, 8'h00, 8'h00}, 0, 0, 1, 0};
    vecs[1] = '{6, {8'h03, 8'h00, 8'h2B, 8'h2B, 8'h2E, 8'h85, 8'h00, 8'h00}, 0, 0, 0, 1};
    vecs[2] = '{3, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1, 0};
    vecs[3] = '{3, {8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0, 1};
    vecs[4] = '{2, {8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0, 1};
    vecs[5] = '{5, {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, 3, 1, 1, 0};
    vecs[6] = '{4, {8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1, 0};
    vecs[7] = '{5, {8'h02, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    reset = 1'b0;
    @(negedge clk);

    // start and valid together in IDLE: the byte must not be taken as len_lo.
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h05;
    chk("idle_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_start_done", done, 1);
    chk("idle_start_error", error, 0);

    for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

    // Reset after the first data byte of a 4-byte frame.
    wr_count = 0;
    pulse_start();
    sb.push_back({10'd0, 8'hAA});
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'hAA);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_imem_we", imem_we, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_writes", wr_count, 1);
    chk("midrst_sb_empty", sb.size(), 0);
    @(negedge clk);
    run_vector(8, vecs[0]);

    // Full-memory program: 1024 bytes, last address 1023.
    wr_count = 0;
    sum = 8'h00;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 1024; i++) begin
      b = 8'(i * 7 + 3);
      sum = sum + b;
      sb.push_back({10'(i), b});
      send_byte(b);
    end
    send_byte(sum);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("max_done", done, 1);
    chk("max_error", error, 0);
    chk("max_writes", wr_count, 1024);
    chk("max_span", last_wr - first_wr, 1023);
    chk("max_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
